ysyx_24100006_axi_sram: RTL and testbench

YSYX_24100006_AXI_SRAM -- requirements
Module: ysyx_24100006_axi_sram

---
 rtl/ysyx_24100006_axi_pkg.sv | 20 ++
 rtl/ysyx_24100006_sram_array.sv | 28 ++
 rtl/ysyx_24100006_axi_sram.sv | 172 +++++++++++++++++
 tb/tb_ysyx_24100006_axi_sram.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24100006_axi_pkg.sv
// rtl/ysyx_24100006_axi_pkg.sv - shared FSM encoding and AXI response codes
package ysyx_24100006_axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DATA,
    WR_DATA,
    WR_RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Next INCR beat address; bit 32 flags a wrap past 32'hFFFF_FFFF.
  function automatic logic [32:0] next_beat(input logic [31:0] addr, input logic [2:0] size);
    return {1'b0, addr} + (33'd1 << size);
  endfunction

endpackage

// File: rtl/ysyx_24100006_sram_array.sv
// rtl/ysyx_24100006_sram_array.sv - byte-enabled word array, synchronous write, asynchronous read
module ysyx_24100006_sram_array #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Contents are deliberately not reset so data survives a bus reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ysyx_24100006_axi_sram.sv
// rtl/ysyx_24100006_axi_sram.sv - single-port AXI4 INCR-burst SRAM slave with fixed read latency
module ysyx_24100006_axi_sram
  import ysyx_24100006_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          RD_LAT      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [7:0]  s_axi_awlen,
  input  logic [2:0]  s_axi_awsize,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [1:0]  s_axi_bresp,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [31:0] s_axi_araddr,
  input  logic [7:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast
);

  localparam int          AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, rdata_q, rdata_d, rd_addr;
  logic [7:0]  len_q, len_d, cnt_q, cnt_d;
  logic [2:0]  size_q, size_d;
  logic [3:0]  lat_q, lat_d;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic        wrap_q, wrap_d, err_q, err_d, rdy_q, rdy_d, wready_q, wready_d;
  logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic        aw_hs, ar_hs, w_hs, r_hs, b_hs, size_bad, beat_last, beat_ok;
  logic        load_r, rd_wrap, rd_ok, mem_we;
  logic [32:0] step;
  logic [31:0] mem_rdata;

  function automatic logic in_range(input logic [31:0] a);
    return (a >= BASE_ADDR) && ({1'b0, a - BASE_ADDR} < SPAN);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  // A pending write blocks arready so AW always wins a simultaneous request.
  assign aw_hs     = rdy_q & s_axi_awvalid;
  assign ar_hs     = rdy_q & ~s_axi_awvalid & s_axi_arvalid;
  assign w_hs      = wready_q & s_axi_wvalid;
  assign r_hs      = rvalid_q & s_axi_rready;
  assign b_hs      = bvalid_q & s_axi_bready;
  assign step      = next_beat(addr_q, size_q);
  assign size_bad  = size_q > 3'd2;
  assign beat_last = cnt_q == len_q;
  assign beat_ok   = ~size_bad & ~wrap_q & in_range(addr_q);

  always_comb begin
    state_d  = state_q;  addr_d   = addr_q;   len_d    = len_q;    size_d  = size_q;
    cnt_d    = cnt_q;    lat_d    = lat_q;    wrap_d   = wrap_q;   err_d   = err_q;
    rdy_d    = rdy_q;    wready_d = wready_q; bvalid_d = bvalid_q; bresp_d = bresp_q;
    rvalid_d = rvalid_q; rlast_d  = rlast_q;  rdata_d  = rdata_q;  rresp_d = rresp_q;
    rd_addr  = addr_q;   rd_wrap  = wrap_q;   load_r   = 1'b0;     mem_we  = 1'b0;
    rd_ok    = 1'b0;
    case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (aw_hs) begin
          state_d = WR_DATA;  addr_d = s_axi_awaddr; len_d = s_axi_awlen; size_d = s_axi_awsize;
          cnt_d   = '0;       wrap_d = 1'b0;         err_d = 1'b0;        rdy_d  = 1'b0;
          wready_d = 1'b1;
        end else if (ar_hs) begin
          state_d = RD_WAIT;  addr_d = s_axi_araddr; len_d = s_axi_arlen; size_d = s_axi_arsize;
          cnt_d   = '0;       wrap_d = 1'b0;         rdy_d = 1'b0;
          lat_d   = 4'(RD_LAT - 1);
        end
      end
      RD_WAIT: begin
        if (lat_q == 4'd0) begin
          state_d = RD_DATA;
          load_r  = 1'b1;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      RD_DATA: begin
        if (r_hs) begin
          if (rlast_q) begin
            state_d = IDLE; rvalid_d = 1'b0; rlast_d = 1'b0; rdy_d = 1'b1;
          end else begin
            addr_d  = step[31:0];  wrap_d  = wrap_q | step[32]; cnt_d = cnt_q + 8'd1;
            rd_addr = step[31:0];  rd_wrap = wrap_q | step[32]; load_r = 1'b1;
          end
        end
      end
      WR_DATA: begin
        if (w_hs) begin
          mem_we = beat_ok;
          err_d  = err_q | ~beat_ok | (s_axi_wlast != beat_last);
          if (beat_last) begin
            state_d  = WR_RESP; wready_d = 1'b0; bvalid_d = 1'b1;
            bresp_d  = err_d ? RESP_SLVERR : RESP_OKAY;
          end else begin
            addr_d = step[31:0]; wrap_d = wrap_q | step[32]; cnt_d = cnt_q + 8'd1;
          end
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          state_d = IDLE; bvalid_d = 1'b0; rdy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Each read beat is captured into the R registers so it holds through stalls.
    if (load_r) begin
      rd_ok    = ~size_bad & ~rd_wrap & in_range(rd_addr);
      rvalid_d = 1'b1;
      rlast_d  = cnt_d == len_q;
      rdata_d  = rd_ok ? mem_rdata : 32'h0;
      rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE; addr_q   <= '0;   len_q    <= '0;   size_q  <= '0;
      cnt_q    <= '0;   lat_q    <= '0;   wrap_q   <= 1'b0; err_q   <= 1'b0;
      rdy_q    <= 1'b0; wready_q <= 1'b0; bvalid_q <= 1'b0; bresp_q <= '0;
      rvalid_q <= 1'b0; rlast_q  <= 1'b0; rdata_q  <= '0;   rresp_q <= '0;
    end else begin
      state_q  <= state_d;  addr_q   <= addr_d;   len_q    <= len_d;    size_q  <= size_d;
      cnt_q    <= cnt_d;    lat_q    <= lat_d;    wrap_q   <= wrap_d;   err_q   <= err_d;
      rdy_q    <= rdy_d;    wready_q <= wready_d; bvalid_q <= bvalid_d; bresp_q <= bresp_d;
      rvalid_q <= rvalid_d; rlast_q  <= rlast_d;  rdata_q  <= rdata_d;  rresp_q <= rresp_d;
    end
  end

  ysyx_24100006_sram_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (word_idx(addr_q)),
    .wdata (s_axi_wdata),
    .wstrb (s_axi_wstrb),
    .raddr (word_idx(rd_addr)),
    .rdata (mem_rdata)
  );

  assign s_axi_awready = rdy_q;
  assign s_axi_arready = rdy_q & ~s_axi_awvalid;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;

endmodule

// File: tb/tb_ysyx_24100006_axi_sram.sv
// tb/tb_ysyx_24100006_axi_sram.sv - randomized self-checking bench with a behavioural memory model
module tb_ysyx_24100006_axi_sram;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam int          LAT   = 2;
  localparam longint      LO    = 64'h8000_0000;
  localparam longint      HI    = LO + 4 * DEPTH;

  logic        clk = 1'b0, reset;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready, s_axi_wlast;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready, s_axi_rlast;
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic [7:0]  s_axi_awlen, s_axi_arlen;
  logic [2:0]  s_axi_awsize, s_axi_arsize;
  logic [3:0]  s_axi_wstrb;
  logic [1:0]  s_axi_bresp, s_axi_rresp;

  int total = 0, bad = 0;
  logic [31:0] ref_mem [int];

  always #5 clk = ~clk;

  ysyx_24100006_axi_sram #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast)
  );

  // Reference model: a beat is served only if its full-precision address lies in [LO, HI).
  function automatic bit beat_in(input longint a, input logic [2:0] size);
    return (size <= 3'd2) && (a >= LO) && (a < HI);
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                                             input logic [31:0] data[$], input logic [3:0] strb[$], input int bad_last);
    bit err = (size > 3'd2) || (bad_last >= 0);
    longint a;
    int k;
    logic [31:0] w;
    for (int i = 0; i <= len; i++) begin
      a = longint'(addr) + longint'(i) * (64'd1 << size);
      if (!beat_in(a, size)) err = 1'b1;
      else begin
        k = int'((a - LO) >> 2);
        w = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
        for (int b = 0; b < 4; b++) if (strb[i][b]) w[8*b +: 8] = data[i][8*b +: 8];
        ref_mem[k] = w;
      end
    end
    return err ? 2'b10 : 2'b00;
  endfunction

  function automatic void model_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                                     output logic [31:0] d[$], output logic [1:0] r[$], output logic l[$]);
    longint a;
    int k;
    d = {}; r = {}; l = {};
    for (int i = 0; i <= len; i++) begin
      a = longint'(addr) + longint'(i) * (64'd1 << size);
      k = int'((a - LO) >> 2);
      if (beat_in(a, size)) begin
        d.push_back(ref_mem.exists(k) ? ref_mem[k] : 32'h0);
        r.push_back(2'b00);
      end else begin
        d.push_back(32'h0);
        r.push_back(2'b10);
      end
      l.push_back(i == len);
    end
  endfunction

  task automatic do_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                          input logic [31:0] data[$], input logic [3:0] strb[$], input int bad_last,
                          input int bdelay, output logic [1:0] resp);
    bit hs;
    resp = 2'bxx;
    @(negedge clk);
    s_axi_awvalid = 1'b1; s_axi_awaddr = addr; s_axi_awlen = len[7:0]; s_axi_awsize = size;
    hs = 1'b0;
    for (int t = 0; t < 50 && !hs; t++) begin #1 hs = s_axi_awready; @(negedge clk); end
    s_axi_awvalid = 1'b0;
    total++;
    if (!hs) begin bad++; $display("FAIL aw_timeout got=no_handshake want=handshake"); end
    for (int i = 0; i <= len; i++) begin
      s_axi_wvalid = 1'b1; s_axi_wdata = data[i]; s_axi_wstrb = strb[i];
      s_axi_wlast = (i == len) ^ (i == bad_last);
      hs = 1'b0;
      for (int t = 0; t < 50 && !hs; t++) begin #1 hs = s_axi_wready; @(negedge clk); end
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    repeat (bdelay) @(negedge clk);
    s_axi_bready = 1'b1;
    hs = 1'b0;
    for (int t = 0; t < 50 && !hs; t++) begin
      #1 hs = s_axi_bvalid;
      if (hs) resp = s_axi_bresp;
      @(negedge clk);
    end
    s_axi_bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [2:0] size, input int mode,
                         output logic [31:0] d[$], output logic [1:0] r[$], output logic l[$], output int lat);
    bit hs, stalled, tog, rr;
    int beats, cyc;
    logic [31:0] hd; logic [1:0] hr; logic hl;
    d = {}; r = {}; l = {};
    @(negedge clk);
    s_axi_arvalid = 1'b1; s_axi_araddr = addr; s_axi_arlen = len[7:0]; s_axi_arsize = size;
    hs = 1'b0;
    for (int t = 0; t < 50 && !hs; t++) begin #1 hs = s_axi_arready; @(negedge clk); end
    s_axi_arvalid = 1'b0;
    lat = 0;
    while (!s_axi_rvalid && lat < 40) begin @(negedge clk); lat++; end
    beats = 0; cyc = 0; stalled = 1'b0; tog = 1'b1;
    while (beats <= len && cyc < 400) begin
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      s_axi_rready = rr;
      if (s_axi_rvalid) begin
        if (stalled) begin
          total++;
          if (s_axi_rdata !== hd || s_axi_rresp !== hr || s_axi_rlast !== hl) begin
            bad++;
            $display("FAIL r_hold got=%h/%b/%b want=%h/%b/%b", s_axi_rdata, s_axi_rresp, s_axi_rlast, hd, hr, hl);
          end
        end
        if (rr) begin
          d.push_back(s_axi_rdata); r.push_back(s_axi_rresp); l.push_back(s_axi_rlast);
          beats++; stalled = 1'b0;
        end else begin
          stalled = 1'b1; hd = s_axi_rdata; hr = s_axi_rresp; hl = s_axi_rlast;
        end
      end
      @(negedge clk);
      cyc++;
    end
    s_axi_rready = 1'b0;
    total++;
    if (beats != len + 1) begin bad++; $display("FAIL r_beats got=%0d want=%0d", beats, len + 1); end
  endtask

  task automatic test_reset;
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_bready = 0; s_axi_rready = 0; s_axi_wlast = 0;
    s_axi_awaddr = 0; s_axi_awlen = 0; s_axi_awsize = 0; s_axi_wdata = 0; s_axi_wstrb = 0;
    s_axi_araddr = 0; s_axi_arlen = 0; s_axi_arsize = 0;
    s_axi_arvalid = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast,
         s_axi_bresp, s_axi_rresp, s_axi_rdata} !== 42'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%b%b%b%b%b%b/%b/%b/%h want=all_zero", s_axi_awready, s_axi_arready,
               s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast, s_axi_bresp, s_axi_rresp, s_axi_rdata);
    end
    s_axi_arvalid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1) begin
      bad++; $display("FAIL idle_ready got=%b%b want=11", s_axi_awready, s_axi_arready);
    end
  endtask

  task automatic preload;
    logic [31:0] dq[$]; logic [3:0] sq[$]; logic [1:0] resp, exp;
    for (int w = 0; w < 2; w++) begin
      dq = {}; sq = {};
      for (int i = 0; i < 128; i++) begin dq.push_back($urandom); sq.push_back(4'hF); end
      exp = model_write(w == 0 ? BASE : 32'(HI - 64'd32), w == 0 ? 127 : 7, 3'd2, dq, sq, -1);
      do_write(w == 0 ? BASE : 32'(HI - 64'd32), w == 0 ? 127 : 7, 3'd2, dq, sq, -1, 0, resp);
      total++;
      if (resp !== exp) begin bad++; $display("FAIL preload_bresp got=%b want=%b", resp, exp); end
    end
  endtask

  task automatic test_single;
    logic [31:0] dq[$], d[$]; logic [3:0] sq[$]; logic [1:0] r[$], resp, exp; logic l[$]; int lat;
    dq = {32'hDEADBEEF}; sq = {4'hF};
    exp = model_write(32'h8000_0010, 0, 3'd2, dq, sq, -1);
    do_write(32'h8000_0010, 0, 3'd2, dq, sq, -1, 1, resp);
    total++;
    if (resp !== exp || resp !== 2'b00) begin bad++; $display("FAIL single_bresp got=%b want=00", resp); end
    do_read(32'h8000_0010, 0, 3'd2, 0, d, r, l, lat);
    total++;
    if (d[0] !== 32'hDEADBEEF || r[0] !== 2'b00 || l[0] !== 1'b1) begin
      bad++; $display("FAIL single_read got=%h/%b/%b want=deadbeef/00/1", d[0], r[0], l[0]);
    end
    total++;
    if (lat !== LAT) begin bad++; $display("FAIL read_latency got=%0d want=%0d", lat, LAT); end
  endtask

  task automatic test_burst_stall;
    logic [31:0] dq[$], d[$], md[$]; logic [3:0] sq[$]; logic [1:0] r[$], mr[$], resp, exp;
    logic l[$], ml[$]; int lat;
    dq = {32'd1, 32'd2, 32'd3, 32'd4}; sq = {4'hF, 4'hF, 4'hF, 4'hF};
    exp = model_write(32'h8000_0100, 3, 3'd2, dq, sq, -1);
    do_write(32'h8000_0100, 3, 3'd2, dq, sq, -1, 0, resp);
    total++;
    if (resp !== exp) begin bad++; $display("FAIL burst_bresp got=%b want=%b", resp, exp); end
    model_read(32'h8000_0100, 3, 3'd2, md, mr, ml);
    do_read(32'h8000_0100, 3, 3'd2, 1, d, r, l, lat);
    for (int i = 0; i < 4 && i < d.size(); i++) begin
      total++;
      if (d[i] !== 32'(i + 1) || l[i] !== (i == 3) || r[i] !== mr[i]) begin
        bad++; $display("FAIL burst_beat%0d got=%h/%b want=%h/%b", i, d[i], l[i], i + 1, i == 3);
      end
    end
  endtask

  task automatic test_strobe;
    logic [31:0] dq[$], d[$]; logic [3:0] sq[$]; logic [1:0] r[$], resp, exp; logic l[$]; int lat;
    dq = {32'hFFFFFFFF}; sq = {4'hF};
    exp = model_write(32'h8000_0040, 0, 3'd2, dq, sq, -1);
    do_write(32'h8000_0040, 0, 3'd2, dq, sq, -1, 0, resp);
    dq = {32'h11223344}; sq = {4'b0101};
    exp = model_write(32'h8000_0040, 0, 3'd2, dq, sq, -1);
    do_write(32'h8000_0040, 0, 3'd2, dq, sq, -1, 0, resp);
    do_read(32'h8000_0040, 0, 3'd2, 0, d, r, l, lat);
    total++;
    if (d[0] !== 32'hFF22FF44 || resp !== exp) begin
      bad++; $display("FAIL strobe_merge got=%h/%b want=ff22ff44/%b", d[0], resp, exp);
    end
  endtask

  task automatic test_arbitration;
    logic [31:0] dq[$], d[$]; logic [3:0] sq[$]; logic [1:0] r[$], exp; logic l[$]; int lat; bit hs, early;
    @(negedge clk);
    s_axi_awvalid = 1; s_axi_awaddr = 32'h8000_0080; s_axi_awlen = 0; s_axi_awsize = 2;
    s_axi_arvalid = 1; s_axi_araddr = 32'h8000_0080; s_axi_arlen = 0; s_axi_arsize = 2;
    #1;
    total++;
    if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b0) begin
      bad++; $display("FAIL arb_ready got=%b%b want=10", s_axi_awready, s_axi_arready);
    end
    @(negedge clk);
    s_axi_awvalid = 0; early = 0;
    s_axi_wvalid = 1; s_axi_wdata = 32'hA5A50F0F; s_axi_wstrb = 4'hF; s_axi_wlast = 1;
    hs = 0;
    for (int t = 0; t < 50 && !hs; t++) begin #1 hs = s_axi_wready; early |= s_axi_arready; @(negedge clk); end
    s_axi_wvalid = 0; s_axi_wlast = 0;
    repeat (2) begin #1 early |= s_axi_arready; @(negedge clk); end
    s_axi_bready = 1; hs = 0;
    for (int t = 0; t < 50 && !hs; t++) begin #1 hs = s_axi_bvalid; early |= s_axi_arready; @(negedge clk); end
    s_axi_bready = 0;
    #1;
    total++;
    if (early !== 1'b0 || s_axi_arready !== 1'b1) begin
      bad++; $display("FAIL arb_read_after_b got=early%b/ar%b want=early0/ar1", early, s_axi_arready);
    end
    dq = {32'hA5A50F0F}; sq = {4'hF};
    exp = model_write(32'h8000_0080, 0, 3'd2, dq, sq, -1);
    do_read(32'h8000_0080, 0, 3'd2, 0, d, r, l, lat);
    total++;
    if (d[0] !== 32'hA5A50F0F || r[0] !== exp) begin
      bad++; $display("FAIL arb_read_data got=%h/%b want=a5a50f0f/%b", d[0], r[0], exp);
    end
  endtask

  task automatic test_errors;
    logic [31:0] dq[$], d[$], md[$]; logic [3:0] sq[$]; logic [1:0] r[$], mr[$], resp, exp;
    logic l[$], ml[$]; int lat;
    do_read(32'h7FFF_FFFC, 0, 3'd2, 0, d, r, l, lat);
    total++;
    if (r[0] !== 2'b10 || d[0] !== 32'h0) begin bad++; $display("FAIL oob_read got=%h/%b want=0/10", d[0], r[0]); end
    dq = {32'hCAFEF00D}; sq = {4'hF};
    exp = model_write(32'(HI), 0, 3'd2, dq, sq, -1);
    do_write(32'(HI), 0, 3'd2, dq, sq, -1, 0, resp);
    total++;
    if (resp !== 2'b10 || exp !== 2'b10) begin bad++; $display("FAIL oob_write got=%b want=10", resp); end
    model_read(BASE, 0, 3'd2, md, mr, ml);
    do_read(BASE, 0, 3'd2, 0, d, r, l, lat);
    total++;
    if (d[0] !== md[0]) begin bad++; $display("FAIL oob_no_alias got=%h want=%h", d[0], md[0]); end
    exp = model_write(32'h8000_0020, 0, 3'd3, dq, sq, -1);
    do_write(32'h8000_0020, 0, 3'd3, dq, sq, -1, 0, resp);
    model_read(32'h8000_0020, 0, 3'd2, md, mr, ml);
    do_read(32'h8000_0020, 0, 3'd2, 0, d, r, l, lat);
    total++;
    if (resp !== 2'b10 || d[0] !== md[0]) begin
      bad++; $display("FAIL size_err got=%b/%h want=10/%h", resp, d[0], md[0]);
    end
    dq = {32'h1, 32'h2}; sq = {4'hF, 4'hF};
    exp = model_write(32'h8000_0030, 1, 3'd2, dq, sq, 0);
    do_write(32'h8000_0030, 1, 3'd2, dq, sq, 0, 0, resp);
    total++;
    if (resp !== 2'b10 || resp !== exp) begin bad++; $display("FAIL wlast_err got=%b want=10", resp); end
    model_read(32'(HI - 64'd8), 3, 3'd2, md, mr, ml);
    do_read(32'(HI - 64'd8), 3, 3'd2, 0, d, r, l, lat);
    for (int i = 0; i < 4 && i < d.size(); i++) begin
      total++;
      if (d[i] !== md[i] || r[i] !== mr[i] || l[i] !== ml[i]) begin
        bad++; $display("FAIL top_edge%0d got=%h/%b want=%h/%b", i, d[i], r[i], md[i], mr[i]);
      end
    end
  endtask

  task automatic test_reset_midburst;
    logic [31:0] d[$], md[$]; logic [1:0] r[$], mr[$]; logic l[$], ml[$]; int lat, t; bit hs;
    @(negedge clk);
    s_axi_arvalid = 1; s_axi_araddr = 32'h8000_0100; s_axi_arlen = 3; s_axi_arsize = 2;
    hs = 0;
    for (t = 0; t < 50 && !hs; t++) begin #1 hs = s_axi_arready; @(negedge clk); end
    s_axi_arvalid = 0;
    t = 0;
    while (!s_axi_rvalid && t < 40) begin @(negedge clk); t++; end
    s_axi_rready = 1;
    @(negedge clk);
    s_axi_rready = 0;
    total++;
    if (s_axi_rvalid !== 1'b1) begin bad++; $display("FAIL mid_beat2_valid got=%b want=1", s_axi_rvalid); end
    reset = 0;
    #1;
    total++;
    if ({s_axi_rvalid, s_axi_rlast, s_axi_rresp, s_axi_rdata} !== 36'h0) begin
      bad++; $display("FAIL mid_reset_clear got=%b/%b/%h want=0/0/0", s_axi_rvalid, s_axi_rlast, s_axi_rdata);
    end
    repeat (2) @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    model_read(32'h8000_0100, 3, 3'd2, md, mr, ml);
    do_read(32'h8000_0100, 3, 3'd2, 0, d, r, l, lat);
    for (int i = 0; i < 4 && i < d.size(); i++) begin
      total++;
      if (d[i] !== md[i] || l[i] !== ml[i]) begin
        bad++; $display("FAIL post_reset_beat%0d got=%h want=%h", i, d[i], md[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] dq[$], d[$], md[$], addr; logic [3:0] sq[$]; logic [1:0] r[$], mr[$], resp, exp;
    logic l[$], ml[$]; logic [2:0] size; int len, lat, pick, bl;
    for (int it = 0; it < 30; it++) begin
      pick = $urandom_range(0, 9);
      size = (pick < 6) ? 3'd2 : (pick < 8) ? 3'(pick - 6) : 3'd3;
      len  = $urandom_range(0, 7);
      if ($urandom_range(0, 3) == 0) addr = 32'(HI - 64'd32) + 32'(4 * $urandom_range(0, 7));
      else addr = BASE + 32'(4 * $urandom_range(0, 119));
      if (size < 3'd2) addr = addr + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        dq = {}; sq = {};
        for (int i = 0; i <= len; i++) begin dq.push_back($urandom); sq.push_back(4'($urandom)); end
        bl = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
        exp = model_write(addr, len, size, dq, sq, bl);
        do_write(addr, len, size, dq, sq, bl, $urandom_range(0, 2), resp);
        total++;
        if (resp !== exp) begin bad++; $display("FAIL rand_bresp it=%0d got=%b want=%b", it, resp, exp); end
      end else begin
        model_read(addr, len, size, md, mr, ml);
        do_read(addr, len, size, 2, d, r, l, lat);
        for (int i = 0; i <= len && i < d.size(); i++) begin
          total++;
          if (d[i] !== md[i] || r[i] !== mr[i] || l[i] !== ml[i]) begin
            bad++;
            $display("FAIL rand_read it=%0d beat=%0d got=%h/%b/%b want=%h/%b/%b", it, i, d[i], r[i], l[i], md[i], mr[i], ml[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_single();
    test_burst_stall();
    test_strobe();
    test_arbitration();
    test_errors();
    test_reset_midburst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
